// File: rtl/apr_pkg.sv
// Shared constants, EBUS function codes and handshake state type for the APR flag controller.
package apr_pkg;

  // EBUS function codes
  localparam logic [2:0] FN_CONO  = 3'd0;
  localparam logic [2:0] FN_CONI  = 3'd1;
  localparam logic [2:0] FN_DATAI = 3'd3;

  localparam int unsigned EBUS_W = 36;

  // Word bit positions, bit 0 = MSB
  localparam int unsigned PI_CH_POS    = 15;
  localparam int unsigned PI_CH_W      = 3;
  localparam int unsigned CONO_LOAD_PI = 18;
  localparam int unsigned CONO_CLR     = 19;
  localparam int unsigned CONO_SET     = 20;
  localparam int unsigned CONO_EN      = 21;
  localparam int unsigned CONO_DIS     = 22;
  localparam int unsigned CONI_ACTIVE  = 18;
  localparam int unsigned DATAI_VALID  = 29;
  localparam int unsigned DATAI_IDX    = 30;
  localparam int unsigned IDX_W        = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WAIT   = 2'd2
  } ebus_state_e;

  // Only CONO, CONI and DATAI are answered
  function automatic logic is_valid_func(input logic [2:0] f);
    return (f == FN_CONO) || (f == FN_CONI) || (f == FN_DATAI);
  endfunction

endpackage

// File: rtl/apr_flag_ctl_if.sv
// EBUS device-side signal bundle.
interface apr_flag_ctl_if;
  logic        ebusDemand;
  logic [0:6]  ds;
  logic [0:2]  ebusFunc;
  logic [0:35] ebusDIn;
  logic [0:35] ebusDOut;
  logic        ebusDrive;
  logic        ebusReturn;

  modport master (
    output ebusDemand, ds, ebusFunc, ebusDIn,
    input  ebusDOut, ebusDrive, ebusReturn
  );

  modport slave (
    input  ebusDemand, ds, ebusFunc, ebusDIn,
    output ebusDOut, ebusDrive, ebusReturn
  );
endinterface

// File: rtl/apr_ebus_slave.sv
// EBUS demand/return handshake and device-select decode.
module apr_ebus_slave
  import apr_pkg::*;
#(
  parameter logic [6:0] DEV = 7'o000
) (
  input  logic        clk,
  input  logic        reset,
  apr_flag_ctl_if.slave ebus,
  input  logic [0:35] i_rdWord,
  output logic        o_conoStrobe_c,
  output logic        o_readStrobe_c,
  output logic [2:0]  o_func,
  output logic [0:35] o_data
);

  ebus_state_e r_state;
  logic        w_accept;
  logic        w_isRead;

  // New transaction: our device, a function we answer
  assign w_accept = ebus.ebusDemand && (ebus.ds == DEV) && is_valid_func(ebus.ebusFunc);
  assign w_isRead = (o_func == FN_CONI) || (o_func == FN_DATAI);

  // Strobes fire on the DECODE cycle that commits to WAIT
  assign o_conoStrobe_c = (r_state == DECODE) && ebus.ebusDemand && (o_func == FN_CONO);
  assign o_readStrobe_c = (r_state == DECODE) && ebus.ebusDemand && w_isRead;

  // Handshake FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      o_func          <= '0;
      o_data          <= '0;
      ebus.ebusDOut   <= '0;
      ebus.ebusDrive  <= 1'b0;
      ebus.ebusReturn <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= DECODE;
            o_func  <= ebus.ebusFunc;
            o_data  <= ebus.ebusDIn;
          end
        end
        DECODE: begin
          if (ebus.ebusDemand) begin
            r_state         <= WAIT;
            ebus.ebusReturn <= 1'b1;
            ebus.ebusDrive  <= o_readStrobe_c;
            ebus.ebusDOut   <= o_readStrobe_c ? i_rdWord : '0;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (!ebus.ebusDemand) begin
            r_state         <= IDLE;
            ebus.ebusReturn <= 1'b0;
            ebus.ebusDrive  <= 1'b0;
            ebus.ebusDOut   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apr_flag_ctl.sv
// APR error/interrupt section: sticky error flags, enable mask, PI channel, first-error latch.
module apr_flag_ctl
  import apr_pkg::*;
#(
  parameter int unsigned NFLAGS = 5,
  parameter logic [6:0]  DEV    = 7'o000,
  parameter int unsigned NPI    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:NFLAGS-1] errIn,
  apr_flag_ctl_if.slave     ebus,
  output logic [1:NPI]      piReq,
  output logic [0:NFLAGS-1] flagsOut
);

  localparam int unsigned SEL_LSB = EBUS_W - NFLAGS;
  localparam int unsigned ENA_LSB = 13 - NFLAGS;

  logic [0:NFLAGS-1] r_flags;
  logic [0:NFLAGS-1] r_en;
  logic [2:0]        r_piChan;
  logic [5:0]        r_firstIdx;
  logic              r_firstValid;

  logic              w_cono;
  logic              w_read;
  logic [2:0]        w_func;
  logic [0:35]       w_data;
  logic [0:35]       w_rdWord;
  logic [0:NFLAGS-1] w_sel;
  logic [0:NFLAGS-1] w_clr;
  logic [0:NFLAGS-1] w_set;
  logic [0:NFLAGS-1] w_ena;
  logic [0:NFLAGS-1] w_dis;
  logic [0:NFLAGS-1] w_flagsNxt;
  logic [0:NFLAGS-1] w_enNxt;
  logic [5:0]        w_lowIdx;
  logic              w_active;
  logic [1:NPI]      w_pi;
  logic              w_unused;

  apr_ebus_slave #(.DEV(DEV)) u_slave (
    .clk            (clk),
    .reset          (reset),
    .ebus           (ebus),
    .i_rdWord       (w_rdWord),
    .o_conoStrobe_c (w_cono),
    .o_readStrobe_c (w_read),
    .o_func         (w_func),
    .o_data         (w_data)
  );

  // Only the select, channel and control bits of a CONO word matter
  assign w_unused = ^w_data ^ w_read;

  assign flagsOut = r_flags;
  assign w_active = |(r_flags & r_en);

  // CONO decode and next flag/enable state; set and errors beat clear
  always_comb begin
    w_sel      = w_data[SEL_LSB +: NFLAGS];
    w_clr      = (w_cono && w_data[CONO_CLR]) ? w_sel : '0;
    w_set      = (w_cono && w_data[CONO_SET]) ? w_sel : '0;
    w_ena      = (w_cono && w_data[CONO_EN])  ? w_sel : '0;
    w_dis      = (w_cono && w_data[CONO_DIS]) ? w_sel : '0;
    w_flagsNxt = (r_flags & ~w_clr) | w_set | errIn;
    w_enNxt    = (r_en & ~w_dis) | w_ena;
  end

  // Lowest-numbered error pulse this cycle
  always_comb begin
    w_lowIdx = '0;
    for (int i = int'(NFLAGS) - 1; i >= 0; i--) begin
      if (errIn[i]) w_lowIdx = 6'(i);
    end
  end

  // CONI / DATAI word from current register state
  always_comb begin
    w_rdWord = '0;
    if (w_func == FN_DATAI) begin
      w_rdWord[DATAI_VALID]          = r_firstValid;
      w_rdWord[DATAI_IDX +: IDX_W]   = r_firstIdx;
    end else begin
      w_rdWord[ENA_LSB +: NFLAGS]    = r_en;
      w_rdWord[PI_CH_POS +: PI_CH_W] = r_piChan;
      w_rdWord[CONI_ACTIVE]          = w_active;
      w_rdWord[SEL_LSB +: NFLAGS]    = r_flags;
    end
  end

  // One-hot request on the programmed channel; channel 0 means none
  always_comb begin
    w_pi = '0;
    for (int k = 1; k <= int'(NPI); k++) begin
      w_pi[k] = w_active && (r_piChan == 3'(k));
    end
  end

  // Flag, enable, channel, first-error and PI request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags      <= '0;
      r_en         <= '0;
      r_piChan     <= '0;
      r_firstIdx   <= '0;
      r_firstValid <= 1'b0;
      piReq        <= '0;
    end else begin
      r_flags <= w_flagsNxt;
      r_en    <= w_enNxt;
      piReq   <= w_pi;
      if (w_cono && w_data[CONO_LOAD_PI]) begin
        r_piChan <= w_data[PI_CH_POS +: PI_CH_W];
      end
      if (!r_firstValid && (|errIn)) begin
        r_firstIdx   <= w_lowIdx;
        r_firstValid <= 1'b1;
      end else if (w_cono && w_data[CONO_CLR] && (w_flagsNxt == '0)) begin
        r_firstValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apr_flag_ctl.sv
// Directed-vector bench for apr_flag_ctl (NFLAGS=5, DEV=0, NPI=7).
module tb_apr_flag_ctl;
  import apr_pkg::*;

  logic       clk;
  logic       reset;
  logic [0:4] errIn;
  logic [1:7] piReq;
  logic [0:4] flagsOut;

  int n_vec = 0;
  int n_err = 0;

  apr_flag_ctl_if ebus();

  apr_flag_ctl #(.NFLAGS(5), .DEV(7'o000), .NPI(7)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .errIn    (errIn),
    .ebus     (ebus),
    .piReq    (piReq),
    .flagsOut (flagsOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: demand, two edges, drop demand, one edge, one idle gap.
  // err_c is driven only during the cycle ending on the commit edge.
  task automatic do_xact(input logic [2:0] fn, input logic [6:0] dsel,
                         input logic [0:35] din, input logic [0:4] err_c,
                         output logic [0:35] rd, output logic ret1, output logic ret2,
                         output logic drv2, output logic ret3, output logic drv3,
                         output logic [1:7] pi2, output logic [1:7] pi3);
    ebus.ebusDemand = 1'b1;
    ebus.ds         = dsel;
    ebus.ebusFunc   = fn;
    ebus.ebusDIn    = din;
    step();
    ret1  = ebus.ebusReturn;
    errIn = err_c;
    step();
    errIn = '0;
    ret2  = ebus.ebusReturn;
    drv2  = ebus.ebusDrive;
    rd    = ebus.ebusDOut;
    pi2   = piReq;
    ebus.ebusDemand = 1'b0;
    step();
    ret3 = ebus.ebusReturn;
    drv3 = ebus.ebusDrive;
    pi3  = piReq;
    step();
  endtask

  logic [0:35] rd, d, e, e_first;
  logic        r1, r2, d2, r3, d3;
  logic [1:7]  p2, p3;
  logic [0:4]  nerr;

  initial begin
    nerr = '0;
    reset = 1'b1;
    errIn = '0;
    ebus.ebusDemand = 1'b0;
    ebus.ds         = '0;
    ebus.ebusFunc   = '0;
    ebus.ebusDIn    = '0;
    repeat (3) step();
    chk("rst_flags",  64'(flagsOut), 64'h0);
    chk("rst_pireq",  64'(piReq), 64'h0);
    chk("rst_return", 64'(ebus.ebusReturn), 64'h0);
    chk("rst_drive",  64'(ebus.ebusDrive), 64'h0);
    reset = 1'b0;
    step();

    // CONI after reset: zero word, latency 2 up, 1 down
    do_xact(FN_CONI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("coni0_ret_d1",  64'(r1), 64'h0);
    chk("coni0_ret_d2",  64'(r2), 64'h1);
    chk("coni0_drive",   64'(d2), 64'h1);
    chk("coni0_word",    64'(rd), 64'h0);
    chk("coni0_ret_off", 64'(r3), 64'h0);
    chk("coni0_drv_off", 64'(d3), 64'h0);

    // errIn[2], then CONO: PI 3, load, enable flag 2
    errIn = 5'b00100;
    step();
    errIn = '0;
    chk("err2_flags", 64'(flagsOut), 64'(5'b00100));
    d = '0; d[15:17] = 3'd3; d[18] = 1'b1; d[21] = 1'b1; d[33] = 1'b1;
    do_xact(FN_CONO, 7'o000, d, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("cono_ret",      64'(r2), 64'h1);
    chk("cono_nodrive",  64'(d2), 64'h0);
    chk("cono_pi_early", 64'(p2), 64'h0);
    chk("cono_pi",       64'(p3), 64'(7'b0010000));

    do_xact(FN_CONI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    e = '0; e[33] = 1'b1; e[10] = 1'b1; e[15:17] = 3'd3; e[18] = 1'b1;
    chk("coni1_word",  64'(rd), 64'(e));
    chk("coni1_bit33", 64'(rd[33]), 64'h1);

    do_xact(FN_DATAI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    e = '0; e[29] = 1'b1; e[30:35] = 6'd2;
    chk("datai_idx2", 64'(rd), 64'(e));

    // Clear all flags: firstValid drops, request drops
    d = '0; d[19] = 1'b1; d[31:35] = 5'b11111;
    do_xact(FN_CONO, 7'o000, d, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("clr1_flags", 64'(flagsOut), 64'h0);
    chk("clr1_pi",    64'(p3), 64'h0);
    do_xact(FN_DATAI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("clr1_valid", 64'(rd[29]), 64'h0);

    // errIn[1] and [3] together: lowest index 1 captured
    errIn = 5'b01010;
    step();
    errIn = '0;
    do_xact(FN_DATAI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    e_first = '0; e_first[29] = 1'b1; e_first[30:35] = 6'd1;
    chk("datai_idx1", 64'(rd), 64'(e_first));
    chk("datai_drv",  64'(d2), 64'h1);
    errIn = 5'b10000;
    step();
    errIn = '0;
    do_xact(FN_DATAI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("datai_keep", 64'(rd), 64'(e_first));
    chk("flags_1_3_0", 64'(flagsOut), 64'(5'b11010));

    // Clear flag 1 while errIn[1] fires on the commit cycle
    d = '0; d[19] = 1'b1; d[32] = 1'b1;
    do_xact(FN_CONO, 7'o000, d, 5'b01000, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("clr_vs_err_flags", 64'(flagsOut), 64'(5'b11010));
    do_xact(FN_DATAI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("clr_vs_err_valid", 64'(rd), 64'(e_first));

    d = '0; d[19] = 1'b1; d[31:35] = 5'b11111;
    do_xact(FN_CONO, 7'o000, d, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("clr2_flags", 64'(flagsOut), 64'h0);
    chk("clr2_pi",    64'(p3), 64'h0);
    do_xact(FN_DATAI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("clr2_valid", 64'(rd[29]), 64'h0);

    // Wrong device: no return, no set
    d = '0; d[20] = 1'b1; d[31:35] = 5'b11111;
    do_xact(FN_CONO, 7'o004, d, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("ds_miss_ret",   64'(r2), 64'h0);
    chk("ds_miss_ret3",  64'(r3), 64'h0);
    chk("ds_miss_flags", 64'(flagsOut), 64'h0);

    // Unassigned function code 2: ignored
    do_xact(3'd2, 7'o000, d, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("fn2_ret",   64'(r2), 64'h0);
    chk("fn2_drv",   64'(d2), 64'h0);
    chk("fn2_flags", 64'(flagsOut), 64'h0);

    // Demand dropped in DECODE: no side effect, no return
    ebus.ebusDemand = 1'b1;
    ebus.ds         = 7'o000;
    ebus.ebusFunc   = FN_CONO;
    ebus.ebusDIn    = d;
    step();
    ebus.ebusDemand = 1'b0;
    step();
    chk("drop_ret", 64'(ebus.ebusReturn), 64'h0);
    step();
    chk("drop_flags", 64'(flagsOut), 64'h0);
    chk("drop_ret2",  64'(ebus.ebusReturn), 64'h0);

    // Set+enable flag 0 on PI 5, then reset in WAIT
    d = '0; d[15:17] = 3'd5; d[18] = 1'b1; d[20] = 1'b1; d[21] = 1'b1; d[31] = 1'b1;
    do_xact(FN_CONO, 7'o000, d, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("pi5_flags", 64'(flagsOut), 64'(5'b10000));
    chk("pi5_req",   64'(p3), 64'(7'b0000100));

    ebus.ebusDemand = 1'b1;
    ebus.ds         = 7'o000;
    ebus.ebusFunc   = FN_CONI;
    ebus.ebusDIn    = '0;
    step();
    step();
    chk("wait_ret", 64'(ebus.ebusReturn), 64'h1);
    chk("wait_drv", 64'(ebus.ebusDrive), 64'h1);
    reset = 1'b1;
    step();
    chk("rstw_ret",   64'(ebus.ebusReturn), 64'h0);
    chk("rstw_drv",   64'(ebus.ebusDrive), 64'h0);
    chk("rstw_flags", 64'(flagsOut), 64'h0);
    reset = 1'b0;
    ebus.ebusDemand = 1'b0;
    step();
    chk("rstw_pi", 64'(piReq), 64'h0);
    do_xact(FN_CONI, 7'o000, '0, nerr, rd, r1, r2, d2, r3, d3, p2, p3);
    chk("rstw_coni_ret",  64'(r2), 64'h1);
    chk("rstw_coni_word", 64'(rd), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
